// File: rtl/switch_pkg.sv
// Shared switch definitions: metadata field layout, port typedefs and
// the per-word qualification outcome used by the egress path.
package switch_pkg;

    localparam int META_WIDTH = 32;
    localparam int DEST_MSB   = 31;
    localparam int DEST_LSB   = 30;
    localparam int SRC_MSB    = 29;
    localparam int SRC_LSB    = 28;
    localparam int PORT_CNT   = 4;

    typedef logic [1:0]            port_t;
    typedef logic [META_WIDTH-1:0] meta_t;

    typedef enum logic [1:0] {
        QUAL_NONE,
        QUAL_MISMATCH,
        QUAL_DROP,
        QUAL_ACCEPT
    } qual_t;

    function automatic port_t meta_dest(input meta_t word);
        return word[DEST_MSB:DEST_LSB];
    endfunction

    function automatic port_t meta_src(input meta_t word);
        return word[SRC_MSB:SRC_LSB];
    endfunction

endpackage

// File: rtl/egress_fifo.sv
// Single-clock FIFO on a synchronous-read RAM with registered full/empty
// flags and a one-cycle-latency read port that pulses rd_valid per pop.
module egress_fifo #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  is_full,
    output logic                  is_empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_OCC = (ADDR_W+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_W-1:0]     wr_ptr_reg;
    logic [ADDR_W-1:0]     rd_ptr_reg;
    logic [ADDR_W:0]       occ_reg;
    logic [ADDR_W:0]       occ_next;
    logic                  full_reg;
    logic                  empty_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  rd_valid_reg;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags are those registered at the start of the cycle, so a write while
    // full is refused even when a read frees a slot in the same cycle.
    assign wr_ok = wr_en && !full_reg;
    assign rd_ok = rd_en && !empty_reg;

    always_comb begin
        occ_next = occ_reg;
        case ({wr_ok, rd_ok})
            2'b10:   occ_next = occ_reg + (ADDR_W+1)'(1);
            2'b01:   occ_next = occ_reg - (ADDR_W+1)'(1);
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            occ_reg      <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            occ_reg      <= occ_next;
            full_reg     <= (occ_next == FULL_OCC);
            empty_reg    <= (occ_next == '0);
            rd_valid_reg <= rd_ok;
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr_reg  <= rd_ptr_reg + ADDR_W'(1);
                rd_data_reg <= mem[rd_ptr_reg];
            end
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign is_full  = full_reg;
    assign is_empty = empty_reg;

endmodule

// File: rtl/egress_buffer.sv
// Output-port receive buffer: qualifies crossbar words against the port id,
// queues accepted words for host readback and keeps saturating statistics.
module egress_buffer
    import switch_pkg::*;
#(
    parameter int PACKET_CNT = 1024,
    parameter int META_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            egress_id,
    input  logic [META_WIDTH-1:0] egress_in,
    input  logic                  egress_in_en,
    input  logic                  clear_stats,
    input  logic                  egress_out_en,
    output logic [META_WIDTH-1:0] egress_out,
    output logic                  egress_out_valid,
    output logic                  is_empty,
    output logic                  is_full,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic [CNT_WIDTH-1:0]  mismatch_cnt,
    input  logic [1:0]            rx_cnt_sel,
    output logic [CNT_WIDTH-1:0]  rx_cnt
);

    // Counter slots 0..PORT_CNT-1 are per-source receive counts.
    localparam int DROP_IDX     = PORT_CNT;
    localparam int MISMATCH_IDX = PORT_CNT + 1;
    localparam int CNT_NUM      = PORT_CNT + 2;

    qual_t               qual;
    port_t               dest;
    port_t               src;
    logic                wr_en;
    logic                rd_en;
    logic [CNT_NUM-1:0]  cnt_event;
    logic [CNT_WIDTH-1:0] cnt_reg [CNT_NUM];

    assign dest = meta_dest(meta_t'(egress_in));
    assign src  = meta_src(meta_t'(egress_in));

    always_comb begin
        qual = QUAL_NONE;
        if (egress_in_en) begin
            if (dest != port_t'(egress_id)) begin
                qual = QUAL_MISMATCH;
            end else if (is_full) begin
                qual = QUAL_DROP;
            end else begin
                qual = QUAL_ACCEPT;
            end
        end
    end

    assign wr_en = (qual == QUAL_ACCEPT);
    assign rd_en = egress_out_en && !is_empty;

    egress_fifo #(
        .DEPTH      (PACKET_CNT),
        .DATA_WIDTH (META_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (egress_in),
        .rd_en    (rd_en),
        .rd_data  (egress_out),
        .rd_valid (egress_out_valid),
        .is_full  (is_full),
        .is_empty (is_empty)
    );

    genvar gi;
    generate
        for (gi = 0; gi < PORT_CNT; gi++) begin : g_rx_event
            assign cnt_event[gi] = wr_en && (src == port_t'(gi));
        end
    endgenerate

    assign cnt_event[DROP_IDX]     = (qual == QUAL_DROP);
    assign cnt_event[MISMATCH_IDX] = (qual == QUAL_MISMATCH);

    // Clear beats a same-cycle increment; counters stick at all-ones.
    generate
        for (gi = 0; gi < CNT_NUM; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (!reset || clear_stats) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_event[gi] && (cnt_reg[gi] != '1)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_WIDTH'(1);
                end
            end
        end
    endgenerate

    assign drop_cnt     = cnt_reg[DROP_IDX];
    assign mismatch_cnt = cnt_reg[MISMATCH_IDX];
    assign rx_cnt       = cnt_reg[{1'b0, rx_cnt_sel}];

endmodule

// File: tb/tb_egress_buffer.sv
// Directed bench for egress_buffer: ordering, full/drop, mismatch, same-cycle
// read/write, empty reads, reset and statistics clear.
module tb_egress_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  egress_id;
    logic [31:0] egress_in;
    logic        egress_in_en;
    logic        clear_stats;
    logic        egress_out_en;
    logic [31:0] egress_out;
    logic        egress_out_valid;
    logic        is_empty;
    logic        is_full;
    logic [15:0] drop_cnt;
    logic [15:0] mismatch_cnt;
    logic [1:0]  rx_cnt_sel;
    logic [15:0] rx_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    egress_buffer dut (
        .clk              (clk),
        .reset            (reset),
        .egress_id        (egress_id),
        .egress_in        (egress_in),
        .egress_in_en     (egress_in_en),
        .clear_stats      (clear_stats),
        .egress_out_en    (egress_out_en),
        .egress_out       (egress_out),
        .egress_out_valid (egress_out_valid),
        .is_empty         (is_empty),
        .is_full          (is_full),
        .drop_cnt         (drop_cnt),
        .mismatch_cnt     (mismatch_cnt),
        .rx_cnt_sel       (rx_cnt_sel),
        .rx_cnt           (rx_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_rx(input string tag, input logic [1:0] sel, input logic [15:0] exp);
        rx_cnt_sel = sel;
        #1;
        chk(tag, {16'h0, rx_cnt}, {16'h0, exp});
    endtask

    task automatic write_word(input logic [31:0] w);
        egress_in    = w;
        egress_in_en = 1'b1;
        tick();
        egress_in_en = 1'b0;
    endtask

    function automatic logic [31:0] fill_word(input int i);
        logic [1:0] s;
        s = 2'(i % 4);
        return {2'b10, s, 28'(i)};
    endfunction

    initial begin
        int n;
        int errs;

        reset         = 1'b0;
        egress_id     = 2'd2;
        egress_in     = '0;
        egress_in_en  = 1'b0;
        clear_stats   = 1'b0;
        egress_out_en = 1'b0;
        rx_cnt_sel    = 2'd0;
        tick();
        tick();
        reset = 1'b1;

        chk("rst_out",      egress_out, 32'h0);
        chk("rst_valid",    {31'h0, egress_out_valid}, 32'h0);
        chk("rst_empty",    {31'h0, is_empty}, 32'h1);
        chk("rst_full",     {31'h0, is_full}, 32'h0);
        chk("rst_drop",     {16'h0, drop_cnt}, 32'h0);
        chk("rst_mismatch", {16'h0, mismatch_cnt}, 32'h0);

        // In-order delivery of three words from different sources
        write_word(32'h8000_0011);
        write_word(32'h9000_0022);
        write_word(32'hB000_0033);
        chk_rx("rx_src0", 2'd0, 16'd1);
        chk_rx("rx_src1", 2'd1, 16'd1);
        chk_rx("rx_src2", 2'd2, 16'd0);
        chk_rx("rx_src3", 2'd3, 16'd1);
        egress_out_en = 1'b1;
        tick();
        chk("rd0_data",  egress_out, 32'h8000_0011);
        chk("rd0_valid", {31'h0, egress_out_valid}, 32'h1);
        tick();
        chk("rd1_data",  egress_out, 32'h9000_0022);
        chk("rd1_valid", {31'h0, egress_out_valid}, 32'h1);
        tick();
        chk("rd2_data",  egress_out, 32'hB000_0033);
        chk("rd2_valid", {31'h0, egress_out_valid}, 32'h1);
        chk("rd2_empty", {31'h0, is_empty}, 32'h1);
        egress_out_en = 1'b0;
        tick();
        chk("idle_valid", {31'h0, egress_out_valid}, 32'h0);
        chk("idle_hold",  egress_out, 32'hB000_0033);

        // Fill to capacity, then write+read while full: write is dropped
        for (int i = 0; i < 1024; i++) begin
            write_word(fill_word(i));
        end
        chk("full_flag", {31'h0, is_full}, 32'h1);
        egress_in     = 32'h8000_0FFF;
        egress_in_en  = 1'b1;
        egress_out_en = 1'b1;
        tick();
        egress_in_en  = 1'b0;
        egress_out_en = 1'b0;
        chk("full_drop",  {16'h0, drop_cnt}, 32'd1);
        chk("full_rd",    egress_out, fill_word(0));
        chk("full_after", {31'h0, is_full}, 32'h0);
        n    = 0;
        errs = 0;
        while (!is_empty && n < 2000) begin
            egress_out_en = 1'b1;
            tick();
            if (egress_out !== fill_word(n + 1) || egress_out_valid !== 1'b1) errs++;
            n++;
        end
        egress_out_en = 1'b0;
        chk("drain_count", 32'(n), 32'd1023);
        chk("drain_data",  32'(errs), 32'd0);
        chk_rx("rx_fill0", 2'd0, 16'd257);
        chk_rx("rx_fill2", 2'd2, 16'd256);

        // Destination mismatch
        egress_id = 2'd0;
        write_word(32'h4000_0005);
        chk("mm_cnt",   {16'h0, mismatch_cnt}, 32'd1);
        chk("mm_empty", {31'h0, is_empty}, 32'h1);
        chk_rx("mm_rx0", 2'd0, 16'd257);
        egress_id = 2'd2;

        // Simultaneous write and read at occupancy 1
        write_word(32'h8000_00AA);
        egress_in     = 32'h9000_00BB;
        egress_in_en  = 1'b1;
        egress_out_en = 1'b1;
        tick();
        egress_in_en = 1'b0;
        chk("rw_data",  egress_out, 32'h8000_00AA);
        chk("rw_valid", {31'h0, egress_out_valid}, 32'h1);
        chk("rw_empty", {31'h0, is_empty}, 32'h0);
        tick();
        egress_out_en = 1'b0;
        chk("rw_next",  egress_out, 32'h9000_00BB);
        chk("rw_last",  {31'h0, is_empty}, 32'h1);

        // Reads while empty, including write+read on an empty FIFO
        egress_out_en = 1'b1;
        tick();
        chk("er_valid", {31'h0, egress_out_valid}, 32'h0);
        chk("er_hold",  egress_out, 32'h9000_00BB);
        egress_in    = 32'h8000_00CC;
        egress_in_en = 1'b1;
        tick();
        egress_in_en = 1'b0;
        chk("erw_valid", {31'h0, egress_out_valid}, 32'h0);
        chk("erw_empty", {31'h0, is_empty}, 32'h0);
        tick();
        egress_out_en = 1'b0;
        chk("erw_data",  egress_out, 32'h8000_00CC);
        chk("erw_vld",   {31'h0, egress_out_valid}, 32'h1);

        // Mid-operation reset discards buffered words and statistics
        for (int i = 0; i < 5; i++) begin
            write_word(fill_word(i));
        end
        chk("pre_drop", {16'h0, drop_cnt}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mr_empty",    {31'h0, is_empty}, 32'h1);
        chk("mr_drop",     {16'h0, drop_cnt}, 32'h0);
        chk("mr_mismatch", {16'h0, mismatch_cnt}, 32'h0);
        chk("mr_out",      egress_out, 32'h0);
        chk_rx("mr_rx0", 2'd0, 16'd0);
        egress_out_en = 1'b1;
        tick();
        egress_out_en = 1'b0;
        chk("mr_rd_valid", {31'h0, egress_out_valid}, 32'h0);

        // Clear during an accepted write: counter zeroed, word still queued
        write_word(32'h9000_0001);
        chk_rx("cl_pre", 2'd1, 16'd1);
        clear_stats = 1'b1;
        write_word(32'h9000_0002);
        clear_stats = 1'b0;
        chk_rx("cl_rx1", 2'd1, 16'd0);
        egress_out_en = 1'b1;
        tick();
        chk("cl_rd0", egress_out, 32'h9000_0001);
        chk("cl_nemp", {31'h0, is_empty}, 32'h0);
        tick();
        egress_out_en = 1'b0;
        chk("cl_rd1", egress_out, 32'h9000_0002);
        chk("cl_empty", {31'h0, is_empty}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
